wb_bus_arbiter_n: RTL

Parametrised N-slave Wishbone-like address decoder and return-path multiplexer.
- Sits between the SPI slave bus master and the TART peripherals (control/reset unit, acquisition unit, and later the visibilities/correlator read-back).
- Replaces the ad-hoc per-device decode, sticky-select and tri-state data mux with one block.
- Adds pipelined-mode outstanding-request tracking, wait-state generation, unmapped-address error and slave-timeout error.

---
 rtl/wb_bus_arbiter_n_pkg.sv | 33 +++
 rtl/wb_bus_arbiter_n_decode.sv | 46 ++++
 rtl/wb_bus_arbiter_n.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/wb_bus_arbiter_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_bus_arbiter_n_pkg
// Description : Shared bus definitions for the TART register bus.
//               - Address map of the peripherals on the 7-bit SPI register bus:
//                 control/reset unit, acquisition unit, visibilities read-back.
//               - clog2 helper used to size occupancy counters.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_bus_arbiter_n_pkg;

    // Control/reset unit: 0x00..0x07
    localparam logic [6:0] C_BASE_CTRL = 7'h00;
    localparam logic [6:0] C_MASK_CTRL = 7'h78;
    // Acquisition unit: 0x0c..0x0f
    localparam logic [6:0] C_BASE_ACQ  = 7'h0c;
    localparam logic [6:0] C_MASK_ACQ  = 7'h7c;
    // Visibilities / correlator read-back: 0x10..0x1f
    localparam logic [6:0] C_BASE_VIS  = 7'h10;
    localparam logic [6:0] C_MASK_VIS  = 7'h70;

    // Number of bits needed to hold values 0..v-1
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_bus_arbiter_n_decode.sv
`default_nettype none
// ============================================================================
// Module      : wb_addr_decode
// Description : Combinational per-slave address match with lowest-index
//               priority.
// Ports       : i_stb  - master strobe (qualifies the miss flag only)
//               i_adr  - master address
//               o_hit  - one-hot winning slave (zero when nothing matches)
//               o_miss - strobe to an address no slave claims
// Revision    : 1.0 - initial release
// ============================================================================
module wb_addr_decode #(
    parameter int                      SLAVES = 3,
    parameter int                      ABITS  = 7,
    parameter logic [SLAVES*ABITS-1:0] BASES  = '0,
    parameter logic [SLAVES*ABITS-1:0] MASKS  = '0
) (
    input  logic              i_stb,
    input  logic [ABITS-1:0]  i_adr,
    output logic [SLAVES-1:0] o_hit,
    output logic              o_miss
);

    logic [SLAVES-1:0] w_match;
    logic              w_found;

    for (genvar g = 0; g < SLAVES; g++) begin : g_match
        assign w_match[g] = ((i_adr & MASKS[g*ABITS +: ABITS]) == BASES[g*ABITS +: ABITS]);
    end

    // Overlapping windows resolve to the lowest slave index.
    always_comb begin
        o_hit   = '0;
        w_found = 1'b0;
        for (int i = 0; i < SLAVES; i++) begin
            if (w_match[i] && !w_found) begin
                o_hit[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

    assign o_miss = i_stb & ~|w_match;

endmodule
`default_nettype wire

// File: rtl/wb_bus_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : wb_bus_arbiter_n
// Description : N-slave Wishbone-like address decoder and return-path mux
//               with outstanding-request tracking, wait states, unmapped
//               address error and slave timeout error.
// Ports       : clk_i, rst_i             - clock, sync active-high reset
//               cyc_i/stb_i/we_i/adr_i/dat_i - master request
//               dat_o/ack_o/err_o/wat_o  - master response / stall
//               s_stb_o/s_we_o/s_adr_o/s_dat_o - slave request fan-out
//               s_ack_i/s_dat_i          - per-slave response (packed)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bus_arbiter_n
    import wb_bus_arbiter_n_pkg::*;
#(
    parameter int                      WIDTH   = 8,
    parameter int                      ABITS   = 7,
    parameter int                      SLAVES  = 3,
    parameter logic [SLAVES*ABITS-1:0] BASES   = {C_BASE_VIS, C_BASE_ACQ, C_BASE_CTRL},
    parameter logic [SLAVES*ABITS-1:0] MASKS   = {C_MASK_VIS, C_MASK_ACQ, C_MASK_CTRL},
    parameter int                      CLASSIC = 1,
    parameter int                      DEPTH   = 4,
    parameter int                      TIMEOUT = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [ABITS-1:0]        adr_i,
    input  logic [WIDTH-1:0]        dat_i,
    output logic [WIDTH-1:0]        dat_o,
    output logic                    ack_o,
    output logic                    err_o,
    output logic                    wat_o,
    output logic [SLAVES-1:0]       s_stb_o,
    output logic                    s_we_o,
    output logic [ABITS-1:0]        s_adr_o,
    output logic [WIDTH-1:0]        s_dat_o,
    input  logic [SLAVES-1:0]       s_ack_i,
    input  logic [SLAVES*WIDTH-1:0] s_dat_i
);

    localparam int              PW          = clog2(DEPTH + 1);
    localparam logic [PW-1:0]   c_PEND_MAX  = PW'(DEPTH);
    localparam logic [PW-1:0]   c_PEND_ONE  = PW'(1);
    localparam logic [7:0]      c_TMO_LIMIT = 8'(TIMEOUT);
    localparam bit              c_CLASSIC   = (CLASSIC != 0);

    logic [SLAVES-1:0] r_sel;
    logic [PW-1:0]     r_pend;
    logic [7:0]        r_tmo;
    logic              r_merr;

    logic [SLAVES-1:0] w_hit;
    logic              w_miss;
    logic              w_busy;
    logic              w_full;
    logic              w_conflict;
    logic              w_wat;
    logic              w_take;
    logic              w_hold;
    logic              w_miss_take;
    logic [SLAVES-1:0] w_sel_eff;
    logic [SLAVES-1:0] w_ackv;
    logic              w_tmo_err;
    logic              w_ret;
    logic [PW-1:0]     w_pend_nxt;
    logic [WIDTH-1:0]  w_dat;

    wb_addr_decode #(
        .SLAVES (SLAVES),
        .ABITS  (ABITS),
        .BASES  (BASES),
        .MASKS  (MASKS)
    ) u_decode (
        .i_stb  (stb_i),
        .i_adr  (adr_i),
        .o_hit  (w_hit),
        .o_miss (w_miss)
    );

    assign w_busy     = (r_pend != '0);
    assign w_full     = c_CLASSIC ? (r_pend == c_PEND_ONE) : (r_pend == c_PEND_MAX);
    // Any strobe not aimed at the outstanding slave waits, so responses
    // always come back in issue order. A miss never matches a live select.
    assign w_conflict = w_busy & stb_i & (w_hit != r_sel);
    assign w_wat      = w_full | w_conflict | r_merr;
    assign wat_o      = w_wat;

    // A miss is taken like any other request; it just produces no strobe.
    assign w_take      = stb_i & cyc_i & ~w_wat;
    assign w_miss_take = w_take & w_miss;

    // Classic slaves expect the strobe for the whole cycle: keep forwarding
    // the held request to its slave while it is outstanding, without
    // counting it again.
    assign w_hold  = c_CLASSIC & stb_i & cyc_i & (r_pend == c_PEND_ONE)
                   & (w_hit == r_sel) & (|w_hit) & ~r_merr;
    assign s_stb_o = (w_take | w_hold) ? w_hit : '0;

    assign s_we_o  = we_i;
    assign s_adr_o = adr_i;
    assign s_dat_o = dat_i;

    // Classic mode allows a same-cycle ack from the slave being strobed.
    assign w_sel_eff = c_CLASSIC ? (r_sel | s_stb_o) : r_sel;
    assign w_ackv    = s_ack_i & w_sel_eff;
    assign ack_o     = |w_ackv;

    always_comb begin
        w_dat = '0;
        for (int i = SLAVES - 1; i >= 0; i--) begin
            if (w_ackv[i]) begin
                w_dat = s_dat_i[i*WIDTH +: WIDTH];
            end
        end
    end
    assign dat_o = w_dat;

    // A real ack in the same cycle as the timeout wins.
    assign w_tmo_err = w_busy & (r_tmo == c_TMO_LIMIT) & ~ack_o;
    assign err_o     = r_merr | w_tmo_err;

    assign w_ret      = ack_o | err_o;
    assign w_pend_nxt = r_pend + PW'(w_take) - PW'(w_ret);

    always_ff @(posedge clk_i) begin
        if (rst_i || !cyc_i) begin
            r_pend <= '0;
            r_sel  <= '0;
            r_tmo  <= '0;
            r_merr <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_merr <= w_miss_take;
            if (w_pend_nxt == '0) begin
                r_sel <= '0;
            end else if (w_take) begin
                r_sel <= w_hit;
            end
            if (!w_busy || ack_o || w_tmo_err) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire
